dma_write_controller: RTL and testbench



---
 rtl/dma_write_controller_pkg.sv | 16 +
 rtl/dma_line_writer.sv | 48 ++++
 rtl/dma_write_controller.sv | 159 +++++++++++++++
 tb/tb_dma_write_controller.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_write_controller_pkg.sv
// Shared widths, hold time and FSM encoding for the DMA write controller.
package dma_write_controller_pkg;

  localparam int DMA_WORD_SIZE  = 16;
  localparam int DMA_LINE_SIZE  = 64;
  localparam int DMA_WRITE_HOLD = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FETCH = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dma_line_writer.sv
// Holds one line's address and data stable for WRITE_HOLD cycles.
// Losing the enable aborts the write so the owner can restart it from scratch.
module dma_line_writer
  import dma_write_controller_pkg::*;
#(
  parameter int WORD_SIZE  = DMA_WORD_SIZE,
  parameter int LINE_SIZE  = DMA_LINE_SIZE,
  parameter int WRITE_HOLD = DMA_WRITE_HOLD
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 enable,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [LINE_SIZE-1:0] line,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] wr_addr,
  output logic [LINE_SIZE-1:0] wr_data
);

  localparam int CNT_W = $clog2(WRITE_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt;

  // Last cycle of the hold window; only counts while the bus is still ours.
  assign done = busy && enable && (hold_cnt == CNT_W'(WRITE_HOLD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      hold_cnt <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      hold_cnt <= '0;
      wr_addr  <= addr;
      wr_data  <= line;
    end else if (busy && (!enable || done)) begin
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else if (busy) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dma_write_controller.sv
// DMA engine: takes a (start address, word count) command, acquires the data bus,
// and copies device lines into memory one held line write at a time.
module dma_write_controller
  import dma_write_controller_pkg::*;
#(
  parameter int WORD_SIZE  = DMA_WORD_SIZE,
  parameter int LINE_SIZE  = DMA_LINE_SIZE,
  parameter int WRITE_HOLD = DMA_WRITE_HOLD
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_length,
  output logic                 bus_req,
  input  logic                 bus_grant,
  input  logic                 dev_valid,
  output logic                 dev_ready,
  input  logic [LINE_SIZE-1:0] dev_line,
  output logic [WORD_SIZE-1:0] d_address,
  output logic                 d_writeM,
  output logic                 d_writeMword,
  output logic [LINE_SIZE-1:0] d_data_out,
  output logic                 d_data_oe,
  output logic                 dma_done
);

  localparam int WORDS_PER_LINE = LINE_SIZE / WORD_SIZE;
  localparam int LINE_SHIFT     = $clog2(WORDS_PER_LINE);
  localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(WORDS_PER_LINE);

  state_t               state;
  logic [WORD_SIZE-1:0] cur_addr;
  logic [WORD_SIZE-1:0] lines_left;
  logic [LINE_SIZE-1:0] buffer;
  logic                 buf_full;
  logic                 dev_ready_q;

  logic [WORD_SIZE:0]   len_round;
  logic [WORD_SIZE-1:0] cmd_lines;
  logic                 capture;
  logic                 wr_start;
  logic [LINE_SIZE-1:0] wr_line;
  logic                 wr_busy;
  logic                 wr_done;
  logic [WORD_SIZE-1:0] wr_addr;
  logic [LINE_SIZE-1:0] wr_data;
  logic                 gate;

  // Round the word count up to whole lines; the device pads a partial last line.
  assign len_round = {1'b0, cmd_length} + (WORD_SIZE + 1)'(WORDS_PER_LINE - 1);
  assign cmd_lines = WORD_SIZE'(len_round >> LINE_SHIFT);

  assign dev_ready = dev_ready_q && bus_grant;
  assign capture   = (state == FETCH) && dev_valid && dev_ready;
  // A retained line (after a lost grant) is replayed without asking the device again.
  assign wr_start  = (state == FETCH) && bus_grant && (buf_full || (dev_valid && dev_ready_q));
  assign wr_line   = buf_full ? buffer : dev_line;

  dma_line_writer #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_SIZE (LINE_SIZE),
    .WRITE_HOLD(WRITE_HOLD)
  ) u_writer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (wr_start),
    .enable (bus_grant),
    .addr   (cur_addr),
    .line   (wr_line),
    .busy   (wr_busy),
    .done   (wr_done),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  // Memory side is gated by the grant combinationally so it drops the cycle the bus is lost.
  assign gate         = wr_busy && bus_grant;
  assign d_writeM     = gate;
  assign d_data_oe    = gate;
  assign d_address    = gate ? wr_addr : '0;
  assign d_data_out   = gate ? wr_data : '0;
  assign d_writeMword = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      bus_req     <= 1'b0;
      dma_done    <= 1'b0;
      cur_addr    <= '0;
      lines_left  <= '0;
      buffer      <= '0;
      buf_full    <= 1'b0;
      dev_ready_q <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cur_addr   <= cmd_addr;
            lines_left <= cmd_lines;
            cmd_ready  <= 1'b0;
            if (cmd_lines == '0) begin
              state    <= DONE;
              dma_done <= 1'b1;
            end else begin
              state   <= REQ;
              bus_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus_grant) begin
            state       <= FETCH;
            dev_ready_q <= !buf_full;
          end
        end
        FETCH: begin
          if (!bus_grant) begin
            state       <= REQ;
            dev_ready_q <= 1'b0;
          end else if (buf_full) begin
            state <= WRITE;
          end else if (capture) begin
            buffer      <= dev_line;
            buf_full    <= 1'b1;
            dev_ready_q <= 1'b0;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (!bus_grant) begin
            state <= REQ;
          end else if (wr_done) begin
            cur_addr   <= cur_addr + STEP;
            lines_left <= lines_left - WORD_SIZE'(1);
            buf_full   <= 1'b0;
            if (lines_left == WORD_SIZE'(1)) begin
              state    <= DONE;
              bus_req  <= 1'b0;
              dma_done <= 1'b1;
            end else begin
              state       <= FETCH;
              dev_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_write_controller.sv
// Directed bench for dma_write_controller: table of transfers plus a mid-write reset sequence.
module tb_dma_write_controller;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_length;
  logic        bus_req;
  logic        bus_grant;
  logic        dev_valid;
  logic        dev_ready;
  logic [63:0] dev_line;
  logic [15:0] d_address;
  logic        d_writeM;
  logic        d_writeMword;
  logic [63:0] d_data_out;
  logic        d_data_oe;
  logic        dma_done;

  dma_write_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_length  (cmd_length),
    .bus_req     (bus_req),
    .bus_grant   (bus_grant),
    .dev_valid   (dev_valid),
    .dev_ready   (dev_ready),
    .dev_line    (dev_line),
    .d_address   (d_address),
    .d_writeM    (d_writeM),
    .d_writeMword(d_writeMword),
    .d_data_out  (d_data_out),
    .d_data_oe   (d_data_oe),
    .dma_done    (dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      addr;
    logic [15:0]      len;
    int               gdly;
    int               stall;
    int               drop;
    bit               spam;
    logic [15:0]      seed;
    int               exp_lines;
    int               exp_nrec;
    logic [3:0][15:0] exp_ra;
    logic [3:0][7:0]  exp_rn;
    int               exp_lat;
    int               exp_cmd_lat;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    int          n;
  } rec_t;

  vec_t        tbl [7];
  rec_t        recs [$];
  logic [15:0] mem [0:65535];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gcyc = -1;
  int done_cyc = -1;
  int cmd_cyc = 0;
  int done_cnt = 0;
  int viol = 0;
  int breq_drops = 0;
  bit breq_seen = 0;
  bit prev_breq = 0;
  int run = 0;
  logic [15:0] cur_a;
  logic [63:0] cur_d;

  logic [15:0] seed = 16'h0;
  int lines_sent = 0;
  int stall_left = 0;
  bit dev_en = 0;

  function automatic logic [63:0] mkline(input logic [15:0] s, input int n);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = s + 16'(4 * n + i);
    return r;
  endfunction

  assign dev_line = mkline(seed, lines_sent);

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] l, input int g,
                              input int s, input int d, input bit sp, input logic [15:0] sd,
                              input int el, input int nr, input logic [63:0] ra,
                              input logic [31:0] rn, input int lat, input int clat);
    vec_t v;
    v.addr = a; v.len = l; v.gdly = g; v.stall = s; v.drop = d; v.spam = sp; v.seed = sd;
    v.exp_lines = el; v.exp_nrec = nr; v.exp_ra = ra; v.exp_rn = rn;
    v.exp_lat = lat; v.exp_cmd_lat = clat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bus/memory observer: collects line-write runs, memory image and protocol violations.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus_grant && gcyc < 0) gcyc = cyc;
      if (dma_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus_req) breq_seen = 1;
      if (prev_breq && !bus_req && !dma_done) breq_drops++;
      prev_breq = bus_req;
      if ((!bus_grant || !d_writeM) && (d_writeM || d_data_oe || d_address != 0 || d_data_out != 0))
        viol++;
      if (d_writeM !== d_data_oe || d_writeMword !== 1'b0) viol++;
      if (d_writeM) begin
        if (run > 0 && d_address == cur_a && d_data_out == cur_d) run++;
        else begin
          if (run > 0) recs.push_back('{cur_a, run});
          run = 1;
          cur_a = d_address;
          cur_d = d_data_out;
        end
        for (int i = 0; i < 4; i++) mem[16'(d_address + 16'(i))] = d_data_out[16*i +: 16];
      end else if (run > 0) begin
        recs.push_back('{cur_a, run});
        run = 0;
      end
    end
  end

  // Device model: one line per handshake, optional stall before the second line.
  initial begin
    bit take;
    bit rdy;
    dev_valid = 1'b0;
    forever begin
      @(negedge clk);
      take = dev_valid && dev_ready;
      rdy  = dev_ready;
      @(posedge clk);
      #1;
      if (take) lines_sent++;
      if (rdy && !take && lines_sent == 1 && stall_left > 0) stall_left--;
      dev_valid = dev_en && !(lines_sent == 1 && stall_left > 0);
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int  waitc;
    int  drop_left;
    int  post;
    bit  granted;
    bit  dropped;
    logic [15:0] la;
    string tag;
    tag = $sformatf("v%0d", idx);
    recs.delete();
    done_cnt = 0; viol = 0; breq_drops = 0; breq_seen = 0; gcyc = -1; done_cyc = -1;
    for (int k = 0; k < v.exp_lines; k++)
      for (int i = 0; i < 4; i++) mem[16'(v.addr + 16'(4 * k + i))] = 16'hdead;
    seed = v.seed; lines_sent = 0; stall_left = v.stall; dev_en = 1;
    @(posedge clk); #1;
    cmd_addr = v.addr; cmd_length = v.len; cmd_valid = 1'b1; cmd_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    granted = 0; dropped = 0; waitc = 0; drop_left = 0; post = 0;
    for (int c = 0; c < 400 && post < 3; c++) begin
      if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) bus_grant = 1'b1;
      end else if (!granted && bus_req) begin
        if (waitc >= v.gdly) begin
          bus_grant = 1'b1;
          granted = 1;
        end else waitc++;
      end
      if (v.drop > 0 && !dropped && run == v.drop) begin
        bus_grant = 1'b0;
        dropped = 1;
        drop_left = 4;
        #1;
        check({tag, "_gate_writeM"}, 64'(d_writeM), 64'h0);
        check({tag, "_gate_addr"}, 64'(d_address), 64'h0);
        check({tag, "_gate_oe"}, 64'(d_data_oe), 64'h0);
      end
      if (v.spam) begin
        cmd_valid = d_writeM; cmd_addr = 16'h0700; cmd_length = 16'd4;
      end
      @(posedge clk); #1;
      if (done_cnt > 0) post++;
    end
    cmd_valid = 1'b0;
    bus_grant = 1'b0;
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'h1);
    check({tag, "_bus_req_after"}, 64'(bus_req), 64'h0);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_mem_violations"}, 64'(viol), 64'd0);
    check({tag, "_bus_req_drops"}, 64'(breq_drops), 64'd0);
    check({tag, "_bus_req_seen"}, 64'(breq_seen), 64'(v.exp_lines != 0));
    check({tag, "_dev_lines"}, 64'(lines_sent), 64'(v.exp_lines));
    check({tag, "_write_runs"}, 64'(recs.size()), 64'(v.exp_nrec));
    for (int r = 0; r < v.exp_nrec; r++) begin
      if (r < recs.size()) begin
        check($sformatf("%s_run%0d_addr", tag, r), 64'(recs[r].a), 64'(v.exp_ra[r]));
        check($sformatf("%s_run%0d_len", tag, r), 64'(recs[r].n), 64'(v.exp_rn[r]));
      end
    end
    for (int k = 0; k < v.exp_lines; k++) begin
      la = 16'(v.addr + 16'(4 * k));
      check($sformatf("%s_mem_line%0d", tag, k),
            {mem[16'(la + 16'd3)], mem[16'(la + 16'd2)], mem[16'(la + 16'd1)], mem[la]},
            mkline(v.seed, k));
    end
    if (v.exp_lat >= 0) check({tag, "_grant_to_done"}, 64'(done_cyc - gcyc), 64'(v.exp_lat));
    if (v.exp_cmd_lat >= 0) check({tag, "_cmd_to_done"}, 64'(done_cyc - cmd_cyc), 64'(v.exp_cmd_lat));
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 16'h0; cmd_length = 16'h0; bus_grant = 1'b0;

    tbl[0] = mk(16'h01f4, 16'd12, 2, 0, 0, 0, 16'h1000, 3, 3,
                {16'h0000, 16'h01fc, 16'h01f8, 16'h01f4}, {8'd0, 8'd5, 8'd5, 8'd5}, -1, -1);
    tbl[1] = mk(16'h0abc, 16'd0, 0, 0, 0, 0, 16'h2000, 0, 0, 64'h0, 32'h0, -1, 2);
    tbl[2] = mk(16'h0100, 16'd12, 0, 10, 0, 0, 16'h3000, 3, 3,
                {16'h0000, 16'h0108, 16'h0104, 16'h0100}, {8'd0, 8'd5, 8'd5, 8'd5}, -1, -1);
    tbl[3] = mk(16'h0200, 16'd12, 1, 0, 3, 0, 16'h4000, 3, 4,
                {16'h0208, 16'h0204, 16'h0200, 16'h0200}, {8'd5, 8'd5, 8'd5, 8'd3}, -1, -1);
    tbl[4] = mk(16'hfffc, 16'd8, 0, 0, 0, 0, 16'h5000, 2, 2,
                {16'h0000, 16'h0000, 16'h0000, 16'hfffc}, {8'd0, 8'd0, 8'd5, 8'd5}, -1, -1);
    tbl[5] = mk(16'h0040, 16'd12, 0, 0, 0, 0, 16'h6000, 3, 3,
                {16'h0000, 16'h0048, 16'h0044, 16'h0040}, {8'd0, 8'd5, 8'd5, 8'd5}, 19, -1);
    tbl[6] = mk(16'h0300, 16'd5, 1, 0, 0, 1, 16'h7000, 2, 2,
                {16'h0000, 16'h0000, 16'h0304, 16'h0300}, {8'd0, 8'd0, 8'd5, 8'd5}, -1, -1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
    check("rst_bus_req", 64'(bus_req), 64'h0);
    check("rst_dev_ready", 64'(dev_ready), 64'h0);
    check("rst_writeM", 64'(d_writeM), 64'h0);
    check("rst_oe", 64'(d_data_oe), 64'h0);
    check("rst_addr", 64'(d_address), 64'h0);
    check("rst_data", d_data_out, 64'h0);
    check("rst_done", 64'(dma_done), 64'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Asynchronous reset in the middle of a line write.
    seed = 16'h8000; lines_sent = 0; stall_left = 0; dev_en = 1;
    bus_grant = 1'b1;
    @(posedge clk); #1;
    cmd_addr = 16'h0800; cmd_length = 16'd12; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < 50 && run < 2; c++) begin
      @(posedge clk); #1;
    end
    check("rstw_write_started", 64'(run >= 2), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstw_writeM", 64'(d_writeM), 64'h0);
    check("rstw_oe", 64'(d_data_oe), 64'h0);
    check("rstw_addr", 64'(d_address), 64'h0);
    check("rstw_data", d_data_out, 64'h0);
    check("rstw_bus_req", 64'(bus_req), 64'h0);
    check("rstw_dev_ready", 64'(dev_ready), 64'h0);
    check("rstw_cmd_ready", 64'(cmd_ready), 64'h1);
    bus_grant = 1'b0;
    dev_en = 0;
    @(posedge clk); #1;
    done_cnt = 0;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rstw_cmd_ready_after", 64'(cmd_ready), 64'h1);
    check("rstw_no_done", 64'(done_cnt), 64'h0);
    check("rstw_bus_req_after", 64'(bus_req), 64'h0);
    run_vec(tbl[0], 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
